// File: rtl/muldiv_iter_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// datapath width, funct3 encodings, FSM state encoding and small decode helpers.
package muldiv_iter_pkg;

   localparam int RV_XLEN = 32;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Divide-class operations all have funct3[2] set.
   function automatic logic f3_is_div(input logic [2:0] f3);
      return f3[2];
   endfunction

   // Only DIV and REM treat their operands as two's-complement values.
   function automatic logic f3_is_signed_div(input logic [2:0] f3);
      return (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/muldiv_iter_signfix.sv
// Combinational sign handling for muldiv_iter.
// Front half: converts operands to magnitudes and derives the result-sign and
// special-case flags when an operation is launched.
// Back half: applies the final two's-complement correction and the
// divide-by-zero / signed-overflow overrides when the result is formed.
module muldiv_signfix
   import muldiv_iter_pkg::*;
#(
   parameter int XLEN = RV_XLEN
) (
   input  logic [2:0]        op_in,
   input  logic [XLEN-1:0]   src_a,
   input  logic [XLEN-1:0]   src_b,
   output logic [XLEN-1:0]   mag_a,
   output logic [XLEN-1:0]   mag_b,
   output logic              neg_res,
   output logic              div_zero,
   output logic              sgn_ovf,

   input  logic [2:0]        fix_op,
   input  logic [2*XLEN-1:0] fix_prod,
   input  logic [XLEN-1:0]   fix_quot,
   input  logic [XLEN-1:0]   fix_rem,
   input  logic              fix_neg,
   input  logic              fix_div_zero,
   input  logic              fix_ovf,
   input  logic [XLEN-1:0]   fix_a_orig,
   output logic [XLEN-1:0]   fix_result
);

   logic              a_sgn_s;
   logic              b_sgn_s;
   logic              a_neg_s;
   logic              b_neg_s;
   logic [2*XLEN-1:0] prod_fix_s;
   logic [XLEN-1:0]   quot_fix_s;
   logic [XLEN-1:0]   rem_fix_s;

   // Decide which operands are signed and compute their magnitudes and flags.
   always_comb begin
      a_sgn_s = 1'b0;
      b_sgn_s = 1'b0;
      case (op_in)
         F3_MULH:   begin a_sgn_s = 1'b1; b_sgn_s = 1'b1; end
         F3_MULHSU: begin a_sgn_s = 1'b1; b_sgn_s = 1'b0; end
         F3_DIV:    begin a_sgn_s = 1'b1; b_sgn_s = 1'b1; end
         F3_REM:    begin a_sgn_s = 1'b1; b_sgn_s = 1'b1; end
         default:   begin a_sgn_s = 1'b0; b_sgn_s = 1'b0; end
      endcase

      a_neg_s = a_sgn_s & src_a[XLEN-1];
      b_neg_s = b_sgn_s & src_b[XLEN-1];

      if (a_neg_s) begin
         mag_a = ~src_a + {{(XLEN-1){1'b0}}, 1'b1};
      end else begin
         mag_a = src_a;
      end

      if (b_neg_s) begin
         mag_b = ~src_b + {{(XLEN-1){1'b0}}, 1'b1};
      end else begin
         mag_b = src_b;
      end

      // A remainder takes the dividend's sign; everything else the XOR of both.
      case (op_in)
         F3_REM:  neg_res = a_neg_s;
         default: neg_res = a_neg_s ^ b_neg_s;
      endcase

      div_zero = (src_b == {XLEN{1'b0}});
      sgn_ovf  = f3_is_signed_div(op_in)
               && (src_a == {1'b1, {(XLEN-1){1'b0}}})
               && (src_b == {XLEN{1'b1}});
   end

   // Apply sign correction, select the requested half/part, then override special cases.
   always_comb begin
      if (fix_neg) begin
         prod_fix_s = ~fix_prod + {{(2*XLEN-1){1'b0}}, 1'b1};
         quot_fix_s = ~fix_quot + {{(XLEN-1){1'b0}}, 1'b1};
         rem_fix_s  = ~fix_rem  + {{(XLEN-1){1'b0}}, 1'b1};
      end else begin
         prod_fix_s = fix_prod;
         quot_fix_s = fix_quot;
         rem_fix_s  = fix_rem;
      end

      fix_result = {XLEN{1'b0}};
      case (fix_op)
         F3_MUL: begin
            fix_result = prod_fix_s[XLEN-1:0];
         end
         F3_MULH, F3_MULHSU, F3_MULHU: begin
            fix_result = prod_fix_s[2*XLEN-1:XLEN];
         end
         F3_DIV, F3_DIVU: begin
            if (fix_div_zero) begin
               fix_result = {XLEN{1'b1}};
            end else if (fix_ovf) begin
               fix_result = {1'b1, {(XLEN-1){1'b0}}};
            end else begin
               fix_result = quot_fix_s;
            end
         end
         F3_REM, F3_REMU: begin
            if (fix_div_zero) begin
               fix_result = fix_a_orig;
            end else if (fix_ovf) begin
               fix_result = {XLEN{1'b0}};
            end else begin
               fix_result = rem_fix_s;
            end
         end
         default: begin
            fix_result = {XLEN{1'b0}};
         end
      endcase
   end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit. Radix-2 shift-add multiply and
// restoring divide share one operand register pair; every operation takes
// 32 datapath iterations plus a fix-up cycle, so latency is constant.
module muldiv_iter
   import muldiv_iter_pkg::*;
#(
   parameter int XLEN = RV_XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   state_e            state_q,  state_d;
   logic [5:0]        cnt_q,    cnt_d;
   logic [2:0]        op_q,     op_d;
   // opa: multiplicand for multiply; dividend shifting out / quotient shifting in for divide.
   logic [XLEN-1:0]   opa_q,    opa_d;
   // opb: multiplier shifting right for multiply; constant divisor for divide.
   logic [XLEN-1:0]   opb_q,    opb_d;
   logic [XLEN-1:0]   a_orig_q, a_orig_d;
   logic [2*XLEN-1:0] acc_q,    acc_d;
   logic [XLEN-1:0]   rem_q,    rem_d;
   logic              neg_q,    neg_d;
   logic              dz_q,     dz_d;
   logic              ovf_q,    ovf_d;
   logic              busy_q,   busy_d;
   logic              done_q,   done_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic [XLEN-1:0]   mag_a_s;
   logic [XLEN-1:0]   mag_b_s;
   logic              neg_s;
   logic              dz_s;
   logic              ovf_s;
   logic [XLEN-1:0]   fix_res_s;

   logic [XLEN:0]     mul_sum_s;
   logic [XLEN:0]     div_shl_s;
   logic [XLEN:0]     div_trial_s;

   muldiv_signfix #(
      .XLEN (XLEN)
   ) u_signfix (
      .op_in        (op),
      .src_a        (src_a),
      .src_b        (src_b),
      .mag_a        (mag_a_s),
      .mag_b        (mag_b_s),
      .neg_res      (neg_s),
      .div_zero     (dz_s),
      .sgn_ovf      (ovf_s),
      .fix_op       (op_q),
      .fix_prod     (acc_q),
      .fix_quot     (opa_q),
      .fix_rem      (rem_q),
      .fix_neg      (neg_q),
      .fix_div_zero (dz_q),
      .fix_ovf      (ovf_q),
      .fix_a_orig   (a_orig_q),
      .fix_result   (fix_res_s)
   );

   // Per-iteration arithmetic: carry-keeping upper-half add and divisor trial subtract.
   always_comb begin
      if (opb_q[0]) begin
         mul_sum_s = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opa_q};
      end else begin
         mul_sum_s = {1'b0, acc_q[2*XLEN-1:XLEN]};
      end
      div_shl_s   = {rem_q, opa_q[XLEN-1]};
      div_trial_s = div_shl_s - {1'b0, opb_q};
   end

   // Next-state and register-update logic for the IDLE/CALC/FIX/DONE sequence.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      a_orig_d = a_orig_q;
      acc_d    = acc_q;
      rem_d    = rem_q;
      neg_d    = neg_q;
      dz_d     = dz_q;
      ovf_d    = ovf_q;
      result_d = result_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d     = op;
               opa_d    = mag_a_s;
               opb_d    = mag_b_s;
               a_orig_d = src_a;
               neg_d    = neg_s;
               dz_d     = dz_s;
               ovf_d    = ovf_s;
               acc_d    = {(2*XLEN){1'b0}};
               rem_d    = {XLEN{1'b0}};
               cnt_d    = 6'd0;
               busy_d   = 1'b1;
               state_d  = ST_CALC;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_CALC: begin
            busy_d = 1'b1;
            if (f3_is_div(op_q)) begin
               // A clear sign bit on the trial means the divisor fits.
               if (!div_trial_s[XLEN]) begin
                  rem_d = div_trial_s[XLEN-1:0];
                  opa_d = {opa_q[XLEN-2:0], 1'b1};
               end else begin
                  rem_d = div_shl_s[XLEN-1:0];
                  opa_d = {opa_q[XLEN-2:0], 1'b0};
               end
            end else begin
               acc_d = {mul_sum_s, acc_q[XLEN-1:1]};
               opb_d = {1'b0, opb_q[XLEN-1:1]};
            end
            if (cnt_q == 6'd31) begin
               cnt_d   = 6'd0;
               state_d = ST_FIX;
            end else begin
               cnt_d   = cnt_q + 6'd1;
            end
         end
         ST_FIX: begin
            busy_d   = 1'b1;
            result_d = fix_res_s;
            state_d  = ST_DONE;
         end
         ST_DONE: begin
            // done is registered, so it is seen the cycle after this state.
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 6'd0;
         op_q     <= 3'd0;
         opa_q    <= {XLEN{1'b0}};
         opb_q    <= {XLEN{1'b0}};
         a_orig_q <= {XLEN{1'b0}};
         acc_q    <= {(2*XLEN){1'b0}};
         rem_q    <= {XLEN{1'b0}};
         neg_q    <= 1'b0;
         dz_q     <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= {XLEN{1'b0}};
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         a_orig_q <= a_orig_d;
         acc_q    <= acc_d;
         rem_q    <= rem_d;
         neg_q    <= neg_d;
         dz_q     <= dz_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: interface-level timing model plus
// arithmetic reference, directed cases and randomized traffic.
module tb_muldiv_iter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op_i = 3'd0;
   logic [31:0] a_i = 32'd0;
   logic [31:0] b_i = 32'd0;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int          n_checks = 0;
   int          n_err = 0;
   bit          chk_en = 1'b0;

   // Model: m_age = -1 when idle, else cycles since the accepted start.
   int          m_age = -1;
   bit          m_done = 1'b0;
   logic [31:0] m_res = 32'd0;
   logic [31:0] m_pend = 32'd0;

   muldiv_iter #(.XLEN(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op_i),
      .src_a  (a_i),
      .src_b  (b_i),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_fn(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      int ia, ib, q;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      ia = a;
      ib = b;
      case (f)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            q = ia / ib;
            return q;
         end
         3'd5: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            q = ia % ib;
            return q;
         end
         default: begin
            if (b == 32'd0) return a;
            return a % b;
         end
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Timing and result model, advanced on each rising edge.
   always @(posedge clk) begin
      if (rst) begin
         m_age  <= -1;
         m_done <= 1'b0;
         m_res  <= 32'd0;
      end else if (m_age >= 0) begin
         if (m_age == 33) begin
            m_age  <= -1;
            m_done <= 1'b1;
            m_res  <= m_pend;
         end else begin
            m_age  <= m_age + 1;
            m_done <= 1'b0;
         end
      end else if (start) begin
         m_age  <= 0;
         m_pend <= ref_fn(op_i, a_i, b_i);
         m_done <= 1'b0;
      end else begin
         m_done <= 1'b0;
      end
   end

   // Compare DUT outputs with the model every cycle, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", {31'd0, busy}, {31'd0, (m_age >= 0)});
         chk("done", {31'd0, done}, {31'd0, m_done});
         if (m_age < 0) chk("result", result, m_res);
      end
   end

   task automatic wait_idle();
      int t = 0;
      while (m_age >= 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) chk("idle_wait", 32'd0, 32'd1);
   endtask

   task automatic wait_done(output logic [31:0] r);
      int t = 0;
      r = 32'hxxxx_xxxx;
      while (!done && t < 60) begin
         @(negedge clk);
         t++;
      end
      chk("done_wait", {31'd0, done}, 32'd1);
      r = result;
   endtask

   task automatic do_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
      int k = 0;
      int bcnt = 0;
      bit got = 1'b0;
      logic [31:0] r = 32'd0;
      wait_idle();
      start = 1'b1; op_i = f; a_i = a; b_i = b;
      while (!got && k < 60) begin
         @(negedge clk);
         start = 1'b0;
         k++;
         if (done) begin
            got = 1'b1;
            r = result;
         end else if (busy) begin
            bcnt++;
         end
      end
      chk({nm, "_done_seen"}, {31'd0, got}, 32'd1);
      chk({nm, "_latency"}, k - 1, 32'd34);
      chk({nm, "_busy_cycles"}, bcnt, 32'd34);
      chk({nm, "_value"}, r, exp);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return $urandom_range(0, 20);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int dn;
      bit restarted;
      logic [31:0] r;

      // Pin the reference model itself to hand-computed values.
      chk("ref_mul",    ref_fn(3'd0, 32'd7, 32'hFFFF_FFFD),          32'hFFFF_FFEB);
      chk("ref_mulh",   ref_fn(3'd1, 32'h8000_0000, 32'h8000_0000),  32'h4000_0000);
      chk("ref_mulhu",  ref_fn(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF),  32'hFFFF_FFFE);
      chk("ref_mulhsu", ref_fn(3'd2, 32'hFFFF_FFFF, 32'd2),          32'hFFFF_FFFF);
      chk("ref_div",    ref_fn(3'd4, 32'hFFFF_FFF9, 32'd2),          32'hFFFF_FFFD);
      chk("ref_rem",    ref_fn(3'd6, 32'hFFFF_FFF9, 32'd2),          32'hFFFF_FFFF);
      chk("ref_divu",   ref_fn(3'd5, 32'd100, 32'd7),                32'd14);
      chk("ref_remu",   ref_fn(3'd7, 32'd100, 32'd7),                32'd2);

      @(posedge clk);
      chk_en = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy",   {31'd0, busy}, 32'd0);
      chk("rst_done",   {31'd0, done}, 32'd0);
      chk("rst_result", result, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      do_op("mul",    3'd0, 32'd7,           32'hFFFF_FFFD, 32'hFFFF_FFEB);
      do_op("mulh",   3'd1, 32'h8000_0000,   32'h8000_0000, 32'h4000_0000);
      do_op("mulhu",  3'd3, 32'hFFFF_FFFF,   32'hFFFF_FFFF, 32'hFFFF_FFFE);
      do_op("mulhsu", 3'd2, 32'hFFFF_FFFF,   32'd2,         32'hFFFF_FFFF);
      do_op("div",    3'd4, 32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFD);
      do_op("rem",    3'd6, 32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFF);
      do_op("divu",   3'd5, 32'd100,         32'd7,         32'd14);
      do_op("remu",   3'd7, 32'd100,         32'd7,         32'd2);
      do_op("div0",   3'd4, 32'h1234_5678,   32'd0,         32'hFFFF_FFFF);
      do_op("rem0",   3'd6, 32'h1234_5678,   32'd0,         32'h1234_5678);
      do_op("divu0",  3'd5, 32'h1234_5678,   32'd0,         32'hFFFF_FFFF);
      do_op("remu0",  3'd7, 32'h1234_5678,   32'd0,         32'h1234_5678);
      do_op("divovf", 3'd4, 32'h8000_0000,   32'hFFFF_FFFF, 32'h8000_0000);
      do_op("removf", 3'd6, 32'h8000_0000,   32'hFFFF_FFFF, 32'd0);

      // Starts during an active operation are ignored; a start in the done cycle is taken.
      wait_idle();
      start = 1'b1; op_i = 3'd5; a_i = 32'd100; b_i = 32'd7;
      dn = 0;
      restarted = 1'b0;
      r = 32'd0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (restarted && c == 36) chk("restart_busy", {31'd0, busy}, 32'd1);
         if (c == 5 || c == 20) begin
            start = 1'b1; op_i = 3'd0; a_i = $urandom; b_i = $urandom;
         end
         if (done) begin
            dn++;
            r = result;
            if (!restarted) begin
               restarted = 1'b1;
               start = 1'b1; op_i = 3'd7; a_i = 32'd100; b_i = 32'd7;
            end
         end
      end
      chk("ignore_done_count", dn, 32'd1);
      chk("ignore_value", r, 32'd14);
      wait_done(r);
      chk("restart_value", r, 32'd2);
      @(negedge clk);

      // Reset in the middle of CALC aborts without a done.
      wait_idle();
      start = 1'b1; op_i = 3'd3; a_i = $urandom; b_i = $urandom;
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy",   {31'd0, busy}, 32'd0);
      chk("abort_done",   {31'd0, done}, 32'd0);
      chk("abort_result", result, 32'd0);
      rst = 1'b0;
      dn = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) dn++;
      end
      chk("abort_no_done", dn, 32'd0);
      do_op("after_abort", 3'd5, 32'd1000, 32'd9, 32'd111);

      // Randomized traffic, including starts while busy and back-to-back launches.
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         start = ($urandom_range(0, 3) == 0);
         op_i  = 3'($urandom_range(0, 7));
         a_i   = pick();
         b_i   = pick();
      end
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
